// File: rtl/slap_colour_mixer_if.sv
// Video/download bus between the sprite pipeline, PROM loader and colour mixer.
// Ports: pixel-rate layer inputs with blanking, PROM download strobe/address/data
//        with per-PROM chip selects, and the 4-bit RGB plus re-aligned blanking out.
interface slap_colour_mixer_if;
  // Pixel-rate inputs
  logic        pix_ce;
  logic [7:0]  sp_pixel;
  logic [7:0]  bg_pixel;
  logic [7:0]  fg_pixel;
  logic [2:0]  layer_en;
  logic        hblank_in;
  logic        vblank_in;

  // Palette PROM download
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic        prom_r_cs;
  logic        prom_g_cs;
  logic        prom_b_cs;
  logic        dn_wr;

  // Video out
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hblank_out;
  logic        vblank_out;

  // Driver side (pixel source / loader / bench)
  modport master (
    output pix_ce, sp_pixel, bg_pixel, fg_pixel, layer_en, hblank_in, vblank_in,
    output dn_addr, dn_data, prom_r_cs, prom_g_cs, prom_b_cs, dn_wr,
    input  red, green, blue, hblank_out, vblank_out
  );

  // Mixer side
  modport slave (
    input  pix_ce, sp_pixel, bg_pixel, fg_pixel, layer_en, hblank_in, vblank_in,
    input  dn_addr, dn_data, prom_r_cs, prom_g_cs, prom_b_cs, dn_wr,
    output red, green, blue, hblank_out, vblank_out
  );
endinterface

// File: rtl/slap_colour_mixer.sv
// Final colour stage: registers sprite/playfield/text pixels, resolves layer
// priority and looks the winning index up in three downloadable 256x4 PROMs.
// Ports: master_clk, reset (sync, active-high), vid (slave modport) carrying
//        pix_ce, layer pixels, layer_en, blanks, download bus, RGB and blanks out.
// Latency: 3 pix_ce pulses input->RGB/blank; pix_ce low freezes the whole pipe.
module slap_colour_mixer #(
  parameter int LATENCY = 3
) (
  input  logic               master_clk,
  input  logic               reset,
  slap_colour_mixer_if.slave vid
);

  // ---------------------------------------------------------------------------
  // Palette PROMs (not reset; contents survive a pipeline reset)
  // ---------------------------------------------------------------------------
  logic [3:0] prom_r_mem [256];
  logic [3:0] prom_g_mem [256];
  logic [3:0] prom_b_mem [256];

  logic [7:0] dn_entry;
  logic [3:0] dn_nibble;

  assign dn_entry  = vid.dn_addr[7:0];
  assign dn_nibble = vid.dn_data[3:0];

  // Download writes run on every master_clk edge regardless of pix_ce. Each
  // chip select is independent, so several selects load the same nibble into
  // several PROMs at once.
  always_ff @(posedge master_clk) begin
    if (vid.dn_wr && vid.prom_r_cs) begin
      prom_r_mem[dn_entry] <= dn_nibble;
    end
    if (vid.dn_wr && vid.prom_g_cs) begin
      prom_g_mem[dn_entry] <= dn_nibble;
    end
    if (vid.dn_wr && vid.prom_b_cs) begin
      prom_b_mem[dn_entry] <= dn_nibble;
    end
  end

  // Upper address and data bits carry no meaning for a 256x4 PROM. The pipe
  // depth is hard-wired at three stages; LATENCY only documents it.
  logic unused_dn_bits;
  logic unused_latency;
  assign unused_dn_bits = ^{vid.dn_addr[24:8], vid.dn_data[7:4]};
  assign unused_latency = (LATENCY == 3);

  // ---------------------------------------------------------------------------
  // Stage 1: capture layer pixels, enables and blanking
  // ---------------------------------------------------------------------------
  logic [7:0] sp1_q, sp1_d;
  logic [7:0] bg1_q, bg1_d;
  logic [7:0] fg1_q, fg1_d;
  logic [2:0] en1_q, en1_d;
  logic       hb1_q, hb1_d;
  logic       vb1_q, vb1_d;

  always_comb begin
    sp1_d = sp1_q;
    bg1_d = bg1_q;
    fg1_d = fg1_q;
    en1_d = en1_q;
    hb1_d = hb1_q;
    vb1_d = vb1_q;
    if (vid.pix_ce) begin
      sp1_d = vid.sp_pixel;
      bg1_d = vid.bg_pixel;
      fg1_d = vid.fg_pixel;
      // layer_en travels with its pixel so toggling a layer never touches
      // pixels already in flight.
      en1_d = vid.layer_en;
      hb1_d = vid.hblank_in;
      vb1_d = vid.vblank_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: opacity and priority (fg > sprite > bg > backdrop 00h)
  // ---------------------------------------------------------------------------
  logic       fg_op;
  logic       sp_op;
  logic       bg_op;
  logic [7:0] idx_sel;

  logic [7:0] idx2_q, idx2_d;
  logic       blank2_q, blank2_d;
  logic       hb2_q, hb2_d;
  logic       vb2_q, vb2_d;

  // Text only has two pixel bits; the rest of fg is palette selection and
  // therefore plays no part in transparency.
  assign fg_op = en1_q[2] & (|fg1_q[1:0]);
  assign sp_op = en1_q[1] & (|sp1_q[3:0]);
  assign bg_op = en1_q[0] & (|bg1_q[3:0]);

  always_comb begin
    idx_sel = 8'h00;
    if (fg_op) begin
      idx_sel = fg1_q;
    end else if (sp_op) begin
      // Sprite palette select sits above its pixel bits.
      idx_sel = {sp1_q[7:4], sp1_q[3:0]};
    end else if (bg_op) begin
      idx_sel = bg1_q;
    end
  end

  always_comb begin
    idx2_d   = idx2_q;
    blank2_d = blank2_q;
    hb2_d    = hb2_q;
    vb2_d    = vb2_q;
    if (vid.pix_ce) begin
      idx2_d   = idx_sel;
      blank2_d = hb1_q | vb1_q;
      hb2_d    = hb1_q;
      vb2_d    = vb1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: synchronous PROM read and blank gating
  // ---------------------------------------------------------------------------
  logic [3:0] prom_r_rd;
  logic [3:0] prom_g_rd;
  logic [3:0] prom_b_rd;

  // The read value is taken before this edge's download write lands, so a
  // same-entry collision shows the old colour for that one pixel.
  always_comb begin
    prom_r_rd = prom_r_mem[idx2_q];
    prom_g_rd = prom_g_mem[idx2_q];
    prom_b_rd = prom_b_mem[idx2_q];
  end

  logic [3:0] red3_q, red3_d;
  logic [3:0] green3_q, green3_d;
  logic [3:0] blue3_q, blue3_d;
  logic       hb3_q, hb3_d;
  logic       vb3_q, vb3_d;

  always_comb begin
    red3_d   = red3_q;
    green3_d = green3_q;
    blue3_d  = blue3_q;
    hb3_d    = hb3_q;
    vb3_d    = vb3_q;
    if (vid.pix_ce) begin
      red3_d   = blank2_q ? 4'h0 : prom_r_rd;
      green3_d = blank2_q ? 4'h0 : prom_g_rd;
      blue3_d  = blank2_q ? 4'h0 : prom_b_rd;
      hb3_d    = hb2_q;
      vb3_d    = vb2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers. Blank flags reset to 1 in every stage so the output
  // stays blanked until real pixels have refilled the pipe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge master_clk) begin
    if (reset) begin
      sp1_q    <= 8'h00;
      bg1_q    <= 8'h00;
      fg1_q    <= 8'h00;
      en1_q    <= 3'b000;
      hb1_q    <= 1'b1;
      vb1_q    <= 1'b1;
      idx2_q   <= 8'h00;
      blank2_q <= 1'b1;
      hb2_q    <= 1'b1;
      vb2_q    <= 1'b1;
      red3_q   <= 4'h0;
      green3_q <= 4'h0;
      blue3_q  <= 4'h0;
      hb3_q    <= 1'b1;
      vb3_q    <= 1'b1;
    end else begin
      sp1_q    <= sp1_d;
      bg1_q    <= bg1_d;
      fg1_q    <= fg1_d;
      en1_q    <= en1_d;
      hb1_q    <= hb1_d;
      vb1_q    <= vb1_d;
      idx2_q   <= idx2_d;
      blank2_q <= blank2_d;
      hb2_q    <= hb2_d;
      vb2_q    <= vb2_d;
      red3_q   <= red3_d;
      green3_q <= green3_d;
      blue3_q  <= blue3_d;
      hb3_q    <= hb3_d;
      vb3_q    <= vb3_d;
    end
  end

  assign vid.red        = red3_q;
  assign vid.green      = green3_q;
  assign vid.blue       = blue3_q;
  assign vid.hblank_out = hb3_q;
  assign vid.vblank_out = vb3_q;

endmodule

// File: doc/slap_colour_mixer.md
# slap_colour_mixer

Final video stage downstream of `sprite_layer`. Registers the sprite pixel alongside the playfield (`bg`) and fixed-text (`fg`) layer pixels, resolves layer priority, and looks the winning 8-bit colour index up in three downloadable 256×4 palette PROMs (R, G, B). Drives 4-bit RGB with blanking re-aligned to the pipeline latency.

## Interface

**Parameters**
- `LATENCY`, default 3: pixel-enable cycles from input sample to RGB out. Fixed; not user-adjustable; exposed for documentation and bench checks only.

**Ports** (clock and reset first)
- `master_clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pix_ce`  in  1  pixel enable, one `master_clk` cycle per pixel; the pipeline advances only when high.
- `sp_pixel`  in  8  sprite pixel from `sprite_layer.pixel_output`: [3:0] pixel bits, [7:4] palette select.
- `bg_pixel`  in  8  playfield colour index; [3:0] pixel bits.
- `fg_pixel`  in  8  text colour index; [1:0] pixel bits.
- `layer_en`  in  3  [0] bg, [1] sprite, [2] fg; 0 forces that layer transparent.
- `hblank_in`, `vblank_in`  in  1 each  blanking, aligned with the pixel inputs.
- `dn_addr`  in  25  download address; [7:0] selects the PROM entry.
- `dn_data`  in  8  download data; [3:0] used.
- `prom_r_cs`, `prom_g_cs`, `prom_b_cs`  in  1 each  download chip selects.
- `dn_wr`  in  1  download write strobe.
- `red`, `green`, `blue`  out  4 each  colour out; 0 while blanked.
- `hblank_out`, `vblank_out`  out  1 each  blanking delayed by `LATENCY`.

## Operation

- **Stage 1 (on `pix_ce`):** latch `sp_pixel`, `bg_pixel`, `fg_pixel`, both blanks, and `layer_en`.
- **Stage 2 (on `pix_ce`):** compute the opacity flags.
  - `fg_op = en[2] & |fg[1:0]`
  - `sp_op = en[1] & |sp[3:0]`
  - `bg_op = en[0] & |bg[3:0]`
  - Register `idx` by priority:
    - `fg_op` → `fg`
    - else `sp_op` → `{sp[7:4], sp[3:0]}`
    - else `bg_op` → `bg`
    - else `8'h00` (backdrop).
  - Register `blank = h|v` plus both blank bits.
- **Stage 3 (on `pix_ce`):** synchronous PROM read at `idx`.
  - `red/green/blue` ← PROM data, or 0 if stage-2 `blank`.
  - `hblank_out/vblank_out` ← stage-2 blank bits.
- **PROM download:**
  - On any `master_clk` edge with `dn_wr` high, write `dn_data[3:0]` to `addr = dn_addr[7:0]` in each PROM whose cs is high. Independent of `pix_ce`.
  - More than one cs high writes all selected PROMs.
  - A write and a display read to the same entry in the same cycle return the old data; the new value appears from the next read.
  - PROM contents are not affected by `reset`.
- **Reset:**
  - All pipeline registers clear: indices 0, layer flags 0.
  - `red/green/blue` = 0; `hblank_out` = `vblank_out` = 1.
  - Reset dominates `pix_ce`.
  - Reset mid-line: the first valid RGB appears `LATENCY` enabled pixels after reset deasserts; blanks read as 1 until the stages refill.
- **`pix_ce` low:** every pipeline register holds, outputs are stable, and downloads still proceed.

## Timing

- Latency: exactly 3 `pix_ce` pulses from input sample to `red/green/blue`, `hblank_out`, `vblank_out`. Pixel N is sampled at pulse k and visible after pulse k+2's edge.
- Input pixel N and blanking N stay paired throughout; there is no skew between colour and blank outputs.
- `pix_ce` back-to-back every cycle: sustained throughput of 1 pixel per cycle.
- `layer_en` takes effect on the pixel sampled with it, not on in-flight pixels.
- Index arithmetic: none. Pure selection; widths are always 8 bits, with no carry or wrap.

## Test plan

- **Download:** load R[i]=i[3:0], G[i]=i[7:4], B[i]=~i[3:0]. Then `sp=8'h00`, `fg=8'h00`, `bg=8'h5A`, unblanked → after 3 ce, RGB = A,5,5.
- **Priority:** `fg=8'h31`, `sp=8'h72`, `bg=8'h5A` → idx 31h. Set `fg=8'h30` → idx 72h. Set `sp=8'h70` → idx 5Ah. All transparent → idx 00h. `layer_en=3'b101` with `sp=8'h72`, `bg=8'h5A` → idx 5Ah.
- **Blanking:** `hblank_in` pulses high for 2 pixels → `hblank_out` high for exactly those 2 pixels, 3 ce later, RGB = 0 throughout. `vblank_out` tracks `vblank_in` the same way.
- **Stall:** `pix_ce` held low for 5 cycles mid-line with changing inputs → outputs unchanged. Resume → sequence continues with no dropped or duplicated pixels.
- **Reset mid-frame:** assert `reset` for 1 cycle during active video → next cycle RGB = 0, blanks = 1. First real pixel appears 3 ce after release. PROM data is retained.
- **Read/write collision:** write R[5Ah]=F while displaying idx 5Ah each ce → the colliding pixel shows the old value, the following pixels show F.
